fpga_ram_nr1w_vld: RTL and testbench

//  Parametrised LUTRAM register file: NR combinational read ports, one write port, DEPTH entries.
//  - Adds a per-entry valid bit, single-cycle flash-invalidate and a live count of valid entries.
//  - Serves as the store for rename/ROB-style tables that must be cleared on pipeline flush

---
 rtl/fpga_ram_nr1w_vld.sv | 95 +++++++++
 tb/tb_fpga_ram_nr1w_vld.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpga_ram_nr1w_vld.sv
// Multi-read / single-write LUTRAM register file with per-entry valid bits, flash flush and a valid count.
// Optional same-cycle write-to-read bypass: define FPGA_RAM_WR_BYPASS_EN.
module fpga_ram_nr1w_vld #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned NR    = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NR*AW-1:0]    raddr,
  output logic [NR*WIDTH-1:0] rdata,
  output logic [NR-1:0]       rvalid,
  input  logic [AW-1:0]       waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                wea,
  input  logic                flush,
  output logic [AW:0]         valid_cnt
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             we_c;
  logic [AW-1:0]    ra;
  logic             r_in;

  // Writes to addresses beyond DEPTH are dropped entirely.
  assign we_c = wea && ({1'b0, waddr} < DEPTH_W);

  // Distributed RAM data array: no reset, data survives a flush.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[waddr] <= wdata;
    end
  end

  // Flush clears first, then the write sets its own entry.
  always_comb begin
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (flush) begin
      vld_d = '0;
      cnt_d = '0;
    end
    if (we_c) begin
      vld_d[waddr] = 1'b1;
      if (flush) begin
        cnt_d = ONE_W;
      end else if (!vld_q[waddr]) begin
        cnt_d = cnt_q + ONE_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_cnt = cnt_q;

  // Zero-latency read ports; invalid or out-of-range entries read as zero.
  always_comb begin
    rdata  = '0;
    rvalid = '0;
    ra     = '0;
    r_in   = 1'b0;
    for (int p = 0; p < NR; p++) begin
      ra   = raddr[p*AW +: AW];
      r_in = ({1'b0, ra} < DEPTH_W);
      if (r_in && vld_q[ra]) begin
        rdata[p*WIDTH +: WIDTH] = mem[ra];
        rvalid[p]               = 1'b1;
      end
`ifdef FPGA_RAM_WR_BYPASS_EN
      if (we_c && (ra == waddr)) begin
        rdata[p*WIDTH +: WIDTH] = wdata;
        rvalid[p]               = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fpga_ram_nr1w_vld.sv
// Directed bench for fpga_ram_nr1w_vld: a DEPTH=64 instance and a DEPTH=48 instance for range checks.
module tb_fpga_ram_nr1w_vld;

  logic        clk;
  logic        rst_n;

  // DEPTH=64 instance (AW=6)
  logic [11:0] raddr;
  logic [63:0] rdata;
  logic [1:0]  rvalid;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        wea;
  logic        flush;
  logic [6:0]  valid_cnt;

  // DEPTH=48 instance (AW=6)
  logic [11:0] raddr2;
  logic [63:0] rdata2;
  logic [1:0]  rvalid2;
  logic [5:0]  waddr2;
  logic [31:0] wdata2;
  logic        wea2;
  logic        flush2;
  logic [6:0]  valid_cnt2;

  int n_checks;
  int n_errors;

  fpga_ram_nr1w_vld #(.WIDTH(32), .DEPTH(64), .NR(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .waddr(waddr), .wdata(wdata), .wea(wea), .flush(flush), .valid_cnt(valid_cnt)
  );

  fpga_ram_nr1w_vld #(.WIDTH(32), .DEPTH(48), .NR(2)) u_dut48 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr2), .rdata(rdata2), .rvalid(rvalid2),
    .waddr(waddr2), .wdata(wdata2), .wea(wea2), .flush(flush2), .valid_cnt(valid_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a0, input int a1);
    raddr = {6'(a1), 6'(a0)};
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    waddr = 6'(a);
    wdata = d;
    wea   = 1'b1;
    tick();
    wea   = 1'b0;
  endtask

  task automatic wr48(input int a, input logic [31:0] d);
    waddr2 = 6'(a);
    wdata2 = d;
    wea2   = 1'b1;
    tick();
    wea2   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; wea = 1'b0; flush = 1'b0;
    raddr2 = '0; waddr2 = '0; wdata2 = '0; wea2 = 1'b0; flush2 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1. reset state across every address
    check("rst_cnt", 64'(valid_cnt), 64'd0);
    for (int a = 0; a < 64; a++) begin
      rd(a, 63 - a);
      check("rst_rv", 64'(rvalid), 64'd0);
      check("rst_rd", rdata, 64'd0);
    end

    // 2. single write, both ports, rewrite keeps count
    wr(5, 32'hDEADBEEF);
    rd(5, 5);
    check("w5_rd", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
    check("w5_rv", 64'(rvalid), 64'd3);
    check("w5_cnt", 64'(valid_cnt), 64'd1);
    wr(5, 32'h1);
    rd(5, 6);
    check("rw5_cnt", 64'(valid_cnt), 64'd1);
    check("rw5_rd", rdata, {32'h0, 32'h1});
    check("rw5_rv", 64'(rvalid), 64'd1);

    // 3. fill, flush, rewrite
    for (int a = 0; a < 64; a++) wr(a, 32'(a * 3 + 7));
    check("fill_cnt", 64'(valid_cnt), 64'd64);
    rd(0, 63);
    check("fill_rd", rdata, {32'd196, 32'd7});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_cnt", 64'(valid_cnt), 64'd0);
    for (int a = 0; a < 64; a += 2) begin
      rd(a, a + 1);
      check("fl_rv", 64'(rvalid), 64'd0);
      check("fl_rd", rdata, 64'd0);
    end
    wr(3, 32'h333);
    rd(3, 4);
    check("w3_rd", rdata, {32'h0, 32'h333});
    check("w3_rv", 64'(rvalid), 64'd1);
    check("w3_cnt", 64'(valid_cnt), 64'd1);

    // 4. flush + write in the same cycle
    wr(1, 32'h11);
    wr(2, 32'h22);
    check("pre4_cnt", 64'(valid_cnt), 64'd3);
    flush = 1'b1; waddr = 6'd10; wdata = 32'hA5; wea = 1'b1;
    tick();
    flush = 1'b0; wea = 1'b0;
    check("fw_cnt", 64'(valid_cnt), 64'd1);
    for (int a = 0; a < 64; a++) begin
      rd(a, 10);
      check("fw_rv", 64'(rvalid), (a == 10) ? 64'd3 : 64'd2);
      check("fw_rd", rdata, {32'hA5, (a == 10) ? 32'hA5 : 32'h0});
    end

    // 5. same-cycle write and read of the same address
    wr(9, 32'h55);
    waddr = 6'd9; wdata = 32'h77; wea = 1'b1;
    rd(9, 10);
`ifdef FPGA_RAM_WR_BYPASS_EN
    check("byp_rd", rdata, {32'hA5, 32'h77});
`else
    check("byp_rd", rdata, {32'hA5, 32'h55});
`endif
    check("byp_rv", 64'(rvalid), 64'd3);
    tick();
    wea = 1'b0;
    #1;
    check("byp_nxt", rdata, {32'hA5, 32'h77});
    // bypass under a concurrent flush; port1 still sees the pre-flush entry 10
    flush = 1'b1; waddr = 6'd9; wdata = 32'h88; wea = 1'b1;
    rd(9, 10);
`ifdef FPGA_RAM_WR_BYPASS_EN
    check("bypf_rd", rdata, {32'hA5, 32'h88});
`else
    check("bypf_rd", rdata, {32'hA5, 32'h77});
`endif
    check("bypf_rv", 64'(rvalid), 64'd3);
    tick();
    flush = 1'b0; wea = 1'b0;
    #1;
    check("bypf_cnt", 64'(valid_cnt), 64'd1);
    check("bypf_rv2", 64'(rvalid), 64'd1);
    check("bypf_rd2", rdata, {32'h0, 32'h88});

    // 6. DEPTH=48: out-of-range write/read and last-entry boundary
    wr48(1, 32'h101);
    wr48(2, 32'h202);
    check("d48_cnt", 64'(valid_cnt2), 64'd2);
    wr48(50, 32'hBAD);
    check("oor_cnt", 64'(valid_cnt2), 64'd2);
    raddr2 = {6'd63, 6'd50};
    #1;
    check("oor_rv", 64'(rvalid2), 64'd0);
    check("oor_rd", rdata2, 64'd0);
    wr48(47, 32'h4747);
    raddr2 = {6'd2, 6'd47};
    #1;
    check("d47_cnt", 64'(valid_cnt2), 64'd3);
    check("d47_rv", 64'(rvalid2), 64'd3);
    check("d47_rd", rdata2, {32'h202, 32'h4747});

    // async reset in the middle of a write burst on both instances
    raddr = {6'd9, 6'd20};
    wea = 1'b1; wea2 = 1'b1;
    for (int i = 20; i < 24; i++) begin
      waddr = 6'(i); waddr2 = 6'(i); wdata = 32'(i); wdata2 = 32'(i);
      tick();
    end
    #2;
    check("pre_rst_rv", 64'(rvalid), 64'd3);
    rst_n = 1'b0;
    #1;
    check("arst_cnt", 64'(valid_cnt), 64'd0);
    check("arst_rv", 64'(rvalid), 64'd0);
    check("arst_rd", rdata, 64'd0);
    check("arst_cnt48", 64'(valid_cnt2), 64'd0);
    check("arst_rv48", 64'(rvalid2), 64'd0);
    wea = 1'b0; wea2 = 1'b0;
    tick();
    check("rst_hold_cnt", 64'(valid_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
